// File: rtl/vga_plot_arbiter_if.sv
// Draw-command bus between the four rectangle requesters and the VGA plot arbiter.
// The master side posts commands and drives stall; the slave side is the arbiter.
interface vga_plot_arbiter_if #(
    parameter int X_W = 11,
    parameter int Y_W = 11
);
    logic [3:0]       req;
    logic [4*X_W-1:0] rx;
    logic [4*Y_W-1:0] ry;
    logic [15:0]      rw;
    logic [15:0]      rh;
    logic [11:0]      rcolour;
    logic             stall;
    logic [3:0]       grant;
    logic [3:0]       done;
    logic             busy;
    logic [X_W-1:0]   xout;
    logic [Y_W-1:0]   yout;
    logic [2:0]       colourout;
    logic             plot;

    modport master (
        output req, rx, ry, rw, rh, rcolour, stall,
        input  grant, done, busy, xout, yout, colourout, plot
    );

    modport slave (
        input  req, rx, ry, rw, rh, rcolour, stall,
        output grant, done, busy, xout, yout, colourout, plot
    );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin owner of the VGA adapter write port: latches one rectangle command,
// rasterizes it row-major at one pixel per cycle with clipping, then pulses done.
module vga_plot_arbiter #(
    parameter int X_W   = 11,
    parameter int Y_W   = 11,
    parameter int H_RES = 160,
    parameter int V_RES = 120
) (
    input  logic               clk,
    input  logic               reset_n,
    vga_plot_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_DONE
    } state_t;

    localparam logic [X_W:0] L_HRES = (X_W+1)'(H_RES);
    localparam logic [Y_W:0] L_VRES = (Y_W+1)'(V_RES);

    state_t         r_state;
    logic [X_W-1:0] r_x0;
    logic [Y_W-1:0] r_y0;
    logic [3:0]     r_w;
    logic [3:0]     r_h;
    logic [3:0]     r_cx;
    logic [3:0]     r_cy;
    logic [2:0]     r_col;
    logic [3:0]     r_grant;
    logic [3:0]     r_done;
    logic [1:0]     r_last;

    logic           w_any;
    logic           w_found;
    logic [1:0]     w_win;
    logic [X_W:0]   w_xsum;
    logic [Y_W:0]   w_ysum;
    logic           w_in_range;

    // Search starts one past the previous owner so every requester is reached within 3 draws.
    always_comb begin
        w_any   = |bus.req;
        w_win   = r_last;
        w_found = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            logic [1:0] cand;
            cand = r_last + 2'(k);
            if (!w_found && bus.req[cand]) begin
                w_win   = cand;
                w_found = 1'b1;
            end
        end
    end

    // One extra bit on each sum so pixels past the coordinate range are clipped, not wrapped.
    always_comb begin
        w_xsum     = {1'b0, r_x0} + (X_W+1)'(r_cx);
        w_ysum     = {1'b0, r_y0} + (Y_W+1)'(r_cy);
        w_in_range = (w_xsum < L_HRES) && (w_ysum < L_VRES);
    end

    assign bus.xout      = w_xsum[X_W-1:0];
    assign bus.yout      = w_ysum[Y_W-1:0];
    assign bus.colourout = r_col;
    assign bus.plot      = (r_state == S_DRAW) && !bus.stall && w_in_range;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.grant     = r_grant;
    assign bus.done      = r_done;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_x0    <= '0;
            r_y0    <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_col   <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_last  <= 2'd3;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_done <= '0;
                    if (w_any) begin
                        r_x0    <= bus.rx[w_win*X_W +: X_W];
                        r_y0    <= bus.ry[w_win*Y_W +: Y_W];
                        r_w     <= bus.rw[w_win*4 +: 4];
                        r_h     <= bus.rh[w_win*4 +: 4];
                        r_col   <= bus.rcolour[w_win*3 +: 3];
                        r_cx    <= '0;
                        r_cy    <= '0;
                        r_grant <= 4'(1) << w_win;
                        r_last  <= w_win;
                        r_state <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (!bus.stall) begin
                        if (r_cx == r_w) begin
                            r_cx <= '0;
                            if (r_cy == r_h) begin
                                r_state <= S_DONE;
                                r_grant <= '0;
                                r_done  <= r_grant;
                            end else begin
                                r_cy <= r_cy + 4'd1;
                            end
                        end else begin
                            r_cx <= r_cx + 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter: expected pixels and done pulses are queued
// ahead of each command and consumed by a negedge monitor as the DUT emits them.
module tb_vga_plot_arbiter;
    localparam int X_W = 11;
    localparam int Y_W = 11;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vga_plot_arbiter_if #(.X_W(X_W), .Y_W(Y_W)) bus ();

    vga_plot_arbiter #(
        .X_W  (X_W),
        .Y_W  (Y_W),
        .H_RES(160),
        .V_RES(120)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    pix_t exp_pix[$];
    int   exp_done[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_rect(input int x, input int y, input int w, input int h, input int c);
        for (int r = 0; r <= h; r++)
            for (int k = 0; k <= w; k++)
                if (x + k < 160 && y + r < 120)
                    exp_pix.push_back('{x: x + k, y: y + r, c: c});
    endtask

    task automatic set_cmd(input int i, input int x, input int y, input int w, input int h, input int c);
        bus.rx[i*X_W +: X_W]  = X_W'(x);
        bus.ry[i*Y_W +: Y_W]  = Y_W'(y);
        bus.rw[i*4 +: 4]      = 4'(w);
        bus.rh[i*4 +: 4]      = 4'(h);
        bus.rcolour[i*3 +: 3] = 3'(c);
    endtask

    // Monitor: every plot and every done pulse must match the head of its queue.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (bus.plot === 1'b1) begin
                if (exp_pix.size() == 0) begin
                    check("unexpected_plot_x", int'(bus.xout), -1);
                end else begin
                    pix_t p;
                    p = exp_pix.pop_front();
                    check("pix_x", int'(bus.xout), p.x);
                    check("pix_y", int'(bus.yout), p.y);
                    check("pix_colour", int'(bus.colourout), p.c);
                end
            end
            if (bus.done !== 4'b0000) begin
                if (exp_done.size() == 0)
                    check("unexpected_done", int'(bus.done), 0);
                else
                    check("done_mask", int'(bus.done), exp_done.pop_front());
            end
        end
    end

    task automatic run_draw(input int idx, input int exp_n, input int s_lo, input int s_hi,
                            input int sx, input int sy);
        int n      = 0;
        int busy_n = 0;
        bit seen   = 1'b0;
        bus.req[idx] = 1'b1;
        while (!seen && n < exp_n + 20) begin
            @(posedge clk);
            #1;
            n++;
            bus.stall = (n >= s_lo && n <= s_hi);
            @(negedge clk);
            if (bus.busy) busy_n++;
            if (n == 1) check("grant", int'(bus.grant), 1 << idx);
            if (bus.stall) begin
                check("stall_plot", int'(bus.plot), 0);
                check("stall_x", int'(bus.xout), sx);
                check("stall_y", int'(bus.yout), sy);
            end
            if (bus.done != 4'b0000) seen = 1'b1;
        end
        check("done_cycle", n, exp_n);
        check("busy_cycles", busy_n, exp_n);
        bus.req[idx] = 1'b0;
        bus.stall    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle_busy", int'(bus.busy), 0);
        check("idle_grant", int'(bus.grant), 0);
    endtask

    task automatic wait_grant_done(input int exp_g, input int exp_lat);
        int n = 0;
        while (bus.grant == 4'b0000 && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("rr_grant", int'(bus.grant), exp_g);
        check("rr_latency", n, exp_lat);
        n = 0;
        while (bus.done == 4'b0000 && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("rr_done_owner", int'(bus.done), exp_g);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        bus.req = '0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bus.req     = '0;
        bus.rx      = '0;
        bus.ry      = '0;
        bus.rw      = '0;
        bus.rh      = '0;
        bus.rcolour = '0;
        bus.stall   = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_grant", int'(bus.grant), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_plot", int'(bus.plot), 0);
        check("rst_xout", int'(bus.xout), 0);
        check("rst_yout", int'(bus.yout), 0);
        check("rst_colour", int'(bus.colourout), 0);
        reset_n = 1'b1;

        // 2x2 from requester 1
        set_cmd(1, 10, 20, 1, 1, 4);
        push_rect(10, 20, 1, 1, 4);
        exp_done.push_back(4'b0010);
        run_draw(1, 5, 0, -1, 0, 0);

        // requesters 0 and 2 held from reset alternate
        apply_reset();
        set_cmd(0, 0, 0, 0, 0, 1);
        set_cmd(2, 5, 6, 1, 0, 2);
        for (int g = 0; g < 2; g++) begin
            push_rect(0, 0, 0, 0, 1);
            exp_done.push_back(4'b0001);
            push_rect(5, 6, 1, 0, 2);
            exp_done.push_back(4'b0100);
        end
        bus.req = 4'b0101;
        wait_grant_done(4'b0001, 1);
        wait_grant_done(4'b0100, 2);
        wait_grant_done(4'b0001, 2);
        wait_grant_done(4'b0100, 2);
        bus.req = '0;
        @(posedge clk);
        @(negedge clk);
        check("rr_idle_busy", int'(bus.busy), 0);

        // 4x1 with a 3-cycle stall on pixel 2
        set_cmd(3, 40, 50, 3, 0, 5);
        push_rect(40, 50, 3, 0, 5);
        exp_done.push_back(4'b1000);
        run_draw(3, 8, 2, 4, 41, 50);

        // right-edge clipping, then x past the coordinate range
        set_cmd(0, 158, 5, 3, 0, 6);
        push_rect(158, 5, 3, 0, 6);
        exp_done.push_back(4'b0001);
        run_draw(0, 5, 0, -1, 0, 0);
        set_cmd(1, 2046, 5, 3, 0, 2);
        push_rect(2046, 5, 3, 0, 2);
        exp_done.push_back(4'b0010);
        run_draw(1, 5, 0, -1, 0, 0);

        // reset during the 3rd DRAW cycle
        set_cmd(2, 30, 30, 3, 1, 7);
        exp_pix.push_back('{x: 30, y: 30, c: 7});
        exp_pix.push_back('{x: 31, y: 30, c: 7});
        bus.req[2] = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            @(posedge clk);
            #1;
            if (n == 3) begin
                reset_n = 1'b0;
                bus.req = '0;
            end
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_grant", int'(bus.grant), 0);
        check("mid_rst_plot", int'(bus.plot), 0);
        check("mid_rst_done", int'(bus.done), 0);
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_pix_left", exp_pix.size(), 0);
        reset_n = 1'b1;
        set_cmd(1, 100, 100, 0, 0, 4);
        set_cmd(3, 7, 8, 0, 0, 6);
        push_rect(100, 100, 0, 0, 4);
        exp_done.push_back(4'b0010);
        push_rect(7, 8, 0, 0, 6);
        exp_done.push_back(4'b1000);
        bus.req = 4'b1010;
        wait_grant_done(4'b0010, 1);
        wait_grant_done(4'b1000, 2);
        bus.req = '0;
        @(posedge clk);
        @(negedge clk);

        // full 16x16 from requester 2
        set_cmd(2, 50, 60, 15, 15, 3);
        push_rect(50, 60, 15, 15, 3);
        exp_done.push_back(4'b0100);
        check("big_last_x", exp_pix[$].x, 65);
        check("big_last_y", exp_pix[$].y, 75);
        run_draw(2, 257, 0, -1, 0, 0);

        check("pix_queue_empty", exp_pix.size(), 0);
        check("done_queue_empty", exp_done.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/vga_plot_arbiter.md
# vga_plot_arbiter

Shares the single VGA adapter write port (x, y, colour, plot) among four draw requesters: the state-square drawers, the ball and the screen clear. Each requester posts a rectangle command; the arbiter grants round-robin, rasterizes the rectangle one pixel per cycle and pulses a per-requester done. It replaces the state-indexed output mux in `graphics` with a handshaked scheduler.

## Interface
- X_W, 11, x coordinate width
- Y_W, 11, y coordinate width
- H_RES, 160, visible columns; pixels with x ≥ H_RES are clipped
- V_RES, 120, visible rows; pixels with y ≥ V_RES are clipped
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low; clock clk
- req  in  4  per-requester draw request, level, held until done
- rx  in  4*X_W  origin x, requester i at [i*X_W +: X_W]
- ry  in  4*Y_W  origin y, requester i at [i*Y_W +: Y_W]
- rw  in  16  width−1 (4 bits each; 0 → 1 pixel, 15 → 16 pixels)
- rh  in  16  height−1 (4 bits each)
- rcolour  in  12  colour (3 bits each)
- stall  in  1  adapter not ready; freezes rasterization
- grant  out  4  one-hot; owner of the port during the draw
- done  out  4  one-cycle pulse to the owner after its last pixel
- busy  out  1  high in DRAW and DONE
- xout  out  X_W  pixel x
- yout  out  Y_W  pixel y
- colourout  out  3  pixel colour
- plot  out  1  pixel write strobe

## Operation
- States: IDLE, DRAW, DONE. Reset → IDLE.
- IDLE: if any req bit is set, choose winner i by round-robin starting from last_grant+1 mod 4. On the same edge: latch rx/ry/rw/rh/rcolour of i into x0/y0/w/h/col, set col=row=0, grant=1<<i, last_grant=i → DRAW. If no req bit is set, remain in IDLE.
- DRAW: xout=x0+col, yout=y0+row, colourout=col reg (combinational from registers).
  - plot = !stall && in_range.
  - in_range: (X_W+1)-bit sum x0+col < H_RES and (Y_W+1)-bit sum y0+row < V_RES. Wrapped or overflowed pixels are never plotted.
  - Each edge with !stall: col++; when col==w, col=0 and row++. Clipped pixels still consume a cycle.
  - Edge with !stall at col==w, row==h → DONE, grant=0, done[i]=1.
  - stall=1: counters, xout and yout hold; plot=0.
- DONE: done[i] high for exactly this cycle; next edge → IDLE, done=0.
- req changes after grant (including deassertion) are ignored; the latched command completes. A requester holding req re-enters arbitration from IDLE.
- Scan order: row-major, x fastest.

## Timing
- Reset values: state IDLE, grant 0, done 0, busy 0, plot 0, x0/y0/col/row/colour regs 0 (so xout=0, yout=0, colourout=0), last_grant=3 (requester 0 has first priority).
- Request to first pixel: req seen at edge k → grant and first pixel visible in cycle k+1.
- Draw occupancy: (w+1)(h+1) DRAW cycles plus stall cycles, then 1 DONE cycle, then 1 IDLE cycle before the next grant. Back-to-back grant gap is 2 cycles.
- Reset asserted mid-DRAW: next edge returns all reset values; no done pulse; the partial rectangle is not resumed.
- Simultaneous requests: exactly one grant; the others wait in rotation. No starvation; maximum wait is 3 draws.

## Test plan
- Reset, then req[1]=1 with x=10, y=20, w=1, h=1, colour=3'b100 → grant=4'b0010 next cycle; plot pixels (10,20), (11,20), (10,21), (11,21) on 4 consecutive cycles; done[1] pulse in cycle 5; then IDLE.
- req[0] and req[2] held high continuously from reset → grant sequence 0, 2, 0, 2; each done pulse matches the current owner.
- stall=1 for 3 cycles while on pixel 2 of a 4×1 draw → plot low for those 3 cycles with xout/yout frozen; 4 pixels total with no duplicates; done 3 cycles later than the unstalled case.
- x=158, w=3, y=5, h=0 → cycles for x=158, 159 have plot=1; x=160, 161 have plot=0; done after 4 DRAW cycles. Also x=2046, w=3 → no plot for the wrapped x=0, 1 pixels.
- reset_n low in the 3rd DRAW cycle → next cycle grant=0, plot=0, done=0, busy=0; a new req[3] is then granted only after req[0..2] priority (last_grant=3).
- w=15, h=15 from requester 2 → 256 plot cycles; final pixel (x0+15, y0+15); busy high for 257 cycles.
